// File: rtl/cdb_arbiter_pkg.sv
// Shared constants and helpers for the common data bus arbiter and its requesters.
package cdb_arbiter_pkg;

  localparam int unsigned CdbNreq  = 4;
  localparam int unsigned CdbTagW  = 4;
  localparam int unsigned CdbXlen  = 32;
  localparam int unsigned CdbSrcW  = 3;
  localparam int unsigned CdbBusyW = 16;

  // Tag 0 means "no producer" and must never appear on the bus.
  localparam logic [CdbTagW-1:0] CdbTagNone = '0;

  localparam int unsigned CdbSrcAlu = 0;
  localparam int unsigned CdbSrcLsb = 1;
  localparam int unsigned CdbSrcBr  = 2;

  typedef logic [CdbBusyW-1:0] busy_cnt_t;

  function automatic busy_cnt_t sat_inc(input busy_cnt_t cnt);
    return (cnt == '1) ? cnt : cnt + 1'b1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Requester handshake and CDB broadcast signals shared by producers and the arbiter.
interface cdb_arbiter_if
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = CdbNreq,
  parameter int unsigned TAG_W = CdbTagW,
  parameter int unsigned XLEN  = CdbXlen
);
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*TAG_W-1:0] req_tag;
  logic [N_REQ*XLEN-1:0]  req_val;
  logic [N_REQ*XLEN-1:0]  req_addr;
  logic [N_REQ-1:0]       req_ready;

  logic                   cdb_active;
  logic [TAG_W-1:0]       cdb_tag;
  logic [XLEN-1:0]        cdb_val;
  logic [XLEN-1:0]        cdb_addr;
  logic [CdbSrcW-1:0]     cdb_src;

  modport master (
    output req_valid, req_tag, req_val, req_addr,
    input  req_ready, cdb_active, cdb_tag, cdb_val, cdb_addr, cdb_src
  );

  modport slave (
    input  req_valid, req_tag, req_val, req_addr,
    output req_ready, cdb_active, cdb_tag, cdb_val, cdb_addr, cdb_src
  );
endinterface

// File: rtl/cdb_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of eligible_i at or after ptr_i, wrapping.
module cdb_arbiter_rr_pick #(
  parameter int unsigned N    = 4,
  parameter int unsigned IdxW = $clog2(N)
) (
  input  logic [N-1:0]    eligible_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [N-1:0]    grant_o,
  output logic [IdxW-1:0] idx_o,
  output logic            any_o
);

  int unsigned j;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    j       = 0;
    for (int unsigned k = 0; k < N; k++) begin
      j = (32'(ptr_i) + k) % N;
      if (!any_o && eligible_i[j]) begin
        any_o      = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = IdxW'(j);
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the common data bus; the winner is registered onto the CDB
// one cycle after its handshake.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = CdbNreq,
  parameter int unsigned TAG_W = CdbTagW,
  parameter int unsigned XLEN  = CdbXlen
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               flush_in,
  cdb_arbiter_if.slave       bus,
  output logic [CdbBusyW-1:0] busy_cnt
);

  localparam int unsigned IdxW = $clog2(N_REQ);

  logic [N_REQ-1:0] eligible, grant;
  logic [IdxW-1:0]  win;
  logic             any;

  logic               active_q, active_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [XLEN-1:0]    val_q, val_d;
  logic [XLEN-1:0]    addr_q, addr_d;
  logic [CdbSrcW-1:0] src_q, src_d;
  logic [IdxW-1:0]    ptr_q, ptr_d;
  busy_cnt_t          busy_q, busy_d;

  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      eligible[i] = bus.req_valid[i] && (bus.req_tag[i*TAG_W +: TAG_W] != '0);
    end
  end

  cdb_arbiter_rr_pick #(
    .N    (N_REQ),
    .IdxW (IdxW)
  ) u_rr_pick (
    .eligible_i (eligible),
    .ptr_i      (ptr_q),
    .grant_o    (grant),
    .idx_o      (win),
    .any_o      (any)
  );

  // Grant is withheld during reset, pause and flush so no transfer can be lost.
  assign bus.req_ready = (rst_in && rdy_in && !flush_in) ? grant : '0;

  always_comb begin
    active_d = active_q;
    tag_d    = tag_q;
    val_d    = val_q;
    addr_d   = addr_q;
    src_d    = src_q;
    ptr_d    = ptr_q;
    busy_d   = busy_q;
    if (rdy_in) begin
      if (flush_in) begin
        active_d = 1'b0;
        ptr_d    = '0;
      end else begin
        if (any) begin
          active_d = 1'b1;
          tag_d    = bus.req_tag[win*TAG_W +: TAG_W];
          val_d    = bus.req_val[win*XLEN +: XLEN];
          addr_d   = bus.req_addr[win*XLEN +: XLEN];
          src_d    = CdbSrcW'(win);
          ptr_d    = (32'(win) == N_REQ - 1) ? '0 : win + 1'b1;
        end else begin
          active_d = 1'b0;
        end
        if ($countones(eligible) >= 2) busy_d = sat_inc(busy_q);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      active_q <= 1'b0;
      tag_q    <= '0;
      val_q    <= '0;
      addr_q   <= '0;
      src_q    <= '0;
      ptr_q    <= '0;
      busy_q   <= '0;
    end else begin
      active_q <= active_d;
      tag_q    <= tag_d;
      val_q    <= val_d;
      addr_q   <= addr_d;
      src_q    <= src_d;
      ptr_q    <= ptr_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.cdb_active = active_q;
  assign bus.cdb_tag    = tag_q;
  assign bus.cdb_val    = val_q;
  assign bus.cdb_addr   = addr_q;
  assign bus.cdb_src    = src_q;
  assign busy_cnt       = busy_q;

  // A valid result carrying the None tag indicates a broken producer.
  always @(posedge clk_in) begin
    if (rst_in && rdy_in) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        assert (!(bus.req_valid[i] && bus.req_tag[i*TAG_W +: TAG_W] == '0))
          else $warning("cdb_arbiter: requester %0d valid with tag 0", i);
      end
    end
  end

endmodule
